// File: rtl/tone_cmd_fifo.sv
// tone_cmd_fifo
// Buffers tone words from the Nios tone PIO and dispatches each one to a
// synthesiser voice selected by the word's top CH_W bits.
//
// Parameters:
//   DATA_W   tone word width (voice index lives in the top CH_W bits)
//   VOICES   number of voice channels, 1..16
//   DEPTH    FIFO entries, power of two, >= 2
//   AF_LEVEL almost-full threshold, 1..DEPTH
//
// Ports:
//   clk_clk      system clock
//   reset_reset  asynchronous reset, active-high
//   ld_fifo      load strobe level; a push happens on its rising edge
//   tone         tone word captured with the push
//   voice_valid  one-hot valid toward the selected voice
//   voice_data   presented word (full width, index field included)
//   voice_ready  per-voice accept
//   fifo_full    FIFO count == DEPTH
//   fifo_afull   FIFO count >= AF_LEVEL
//   fifo_empty   FIFO count == 0 and nothing presented
//   ovf          sticky overflow flag, set on a dropped push
//   ovf_clr      synchronous clear for ovf (and ovf_count)
//   bad_voice    one-cycle pulse when a word with an out-of-range index
//                is discarded
//   ovf_count    16-bit saturating drop counter, present only when the
//                macro TONE_FIFO_OVF_CNT_EN is defined
//
// Output stage FSM:
//   state   | meaning
//   IDLE    | no word presented, voice_valid = 0
//   PRESENT | word held in voice_data, valid on its voice until accepted

module tone_cmd_fifo #(
  parameter int DATA_W   = 32,
  parameter int VOICES   = 4,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              ld_fifo,
  input  logic [DATA_W-1:0] tone,
  output logic [VOICES-1:0] voice_valid,
  output logic [DATA_W-1:0] voice_data,
  input  logic [VOICES-1:0] voice_ready,
  output logic              fifo_full,
  output logic              fifo_afull,
  output logic              fifo_empty,
  output logic              ovf,
  input  logic              ovf_clr,
  output logic              bad_voice
`ifdef TONE_FIFO_OVF_CNT_EN
  ,
  output logic [15:0]       ovf_count
`endif
);

  localparam int CH_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int AW   = $clog2(DEPTH);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [4:0]  VOICES_C = 5'(VOICES);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t state, state_nx;

  logic              ld_q;
  logic              push_req;
  logic              push_acc;
  logic              drop;
  logic              pop;
  logic              load;
  logic              bad_pop;
  logic              xfer;
  logic              nonempty;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count, count_nx;

  logic [DATA_W-1:0] head;
  logic [CH_W-1:0]   head_idx;
  logic [CH_W-1:0]   out_idx;
  logic              head_bad;

  assign push_req = ld_fifo & ~ld_q;
  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];
  assign head_idx = head[DATA_W-1 -: CH_W];
  assign out_idx  = voice_data[DATA_W-1 -: CH_W];
  assign head_bad = (5'(head_idx) >= VOICES_C);

  always_comb begin
    voice_valid = '0;
    for (int i = 0; i < VOICES; i++) begin
      voice_valid[i] = (state == PRESENT) && (5'(out_idx) == 5'(i));
    end
  end

  // Only the selected voice's ready matters since voice_valid is one-hot.
  assign xfer = (state == PRESENT) && |(voice_ready & voice_valid);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    bad_pop  = 1'b0;
    case (state)
      IDLE: begin
        if (nonempty) begin
          pop = 1'b1;
          if (head_bad) begin
            bad_pop = 1'b1;
          end else begin
            load     = 1'b1;
            state_nx = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (xfer) begin
          if (nonempty) begin
            pop = 1'b1;
            if (head_bad) begin
              bad_pop  = 1'b1;
              state_nx = IDLE;
            end else begin
              load = 1'b1;
            end
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_acc = push_req && ((count != DEPTH_C) || pop);
  assign drop     = push_req && !push_acc;
  assign count_nx = count + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop};

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= tone;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ld_q       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_afull <= 1'b0;
      fifo_empty <= 1'b1;
      ovf        <= 1'b0;
      bad_voice  <= 1'b0;
      voice_data <= '0;
    end else begin
      ld_q       <= ld_fifo;
      count      <= count_nx;
      fifo_full  <= (count_nx == DEPTH_C);
      fifo_afull <= (count_nx >= AF_C);
      fifo_empty <= (count_nx == '0) && (state_nx == IDLE);
      bad_voice  <= bad_pop;
      if (push_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (load) begin
        voice_data <= head;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef TONE_FIFO_OVF_CNT_EN
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ovf_count <= '0;
    end else if (ovf_clr) begin
      ovf_count <= drop ? 16'd1 : 16'd0;
    end else if (drop && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tone_cmd_fifo.sv
// tb_tone_cmd_fifo
// Directed bench for tone_cmd_fifo. dut4 uses the default VOICES = 4;
// dut3 uses VOICES = 3 so that index 3 is out of range.

module tb_tone_cmd_fifo;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [31:0] tone;
  logic [3:0]  ready;
  logic        ovf_clr;
  logic [3:0]  valid;
  logic [31:0] data;
  logic        full, afull, empty, ovf, bad;

  logic        ld3;
  logic [31:0] tone3;
  logic [2:0]  ready3;
  logic [2:0]  valid3;
  logic [31:0] data3;
  logic        full3, afull3, empty3, ovf3, bad3;

`ifdef TONE_FIFO_OVF_CNT_EN
  logic [15:0] ovf_count;
  logic [15:0] ovf_count3;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  tone_cmd_fifo #(.DATA_W(32), .VOICES(4), .DEPTH(16), .AF_LEVEL(12)) dut4 (
    .clk_clk(clk), .reset_reset(rst), .ld_fifo(ld), .tone(tone),
    .voice_valid(valid), .voice_data(data), .voice_ready(ready),
    .fifo_full(full), .fifo_afull(afull), .fifo_empty(empty),
    .ovf(ovf), .ovf_clr(ovf_clr), .bad_voice(bad)
`ifdef TONE_FIFO_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  tone_cmd_fifo #(.DATA_W(32), .VOICES(3), .DEPTH(16), .AF_LEVEL(12)) dut3 (
    .clk_clk(clk), .reset_reset(rst), .ld_fifo(ld3), .tone(tone3),
    .voice_valid(valid3), .voice_data(data3), .voice_ready(ready3),
    .fifo_full(full3), .fifo_afull(afull3), .fifo_empty(empty3),
    .ovf(ovf3), .ovf_clr(ovf_clr), .bad_voice(bad3)
`ifdef TONE_FIFO_OVF_CNT_EN
    , .ovf_count(ovf_count3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    tone = w;
    ld   = 1'b1;
    tick();
    ld   = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] fill_word(input int k);
    logic [31:0] r;
    r        = 32'(k);
    r[31:30] = 2'(k % 4);
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", valid); end
    n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data); end
    n_checks++; if ({full, afull, empty} !== 3'b001) begin n_fail++; $display("FAIL reset_flags: got %b want 001", {full, afull, empty}); end
    n_checks++; if ({ovf, bad} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf_bad: got %b want 00", {ovf, bad}); end
`ifdef TONE_FIFO_OVF_CNT_EN
    n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL reset_ovf_count: got %0d want 0", ovf_count); end
`endif
    rst = 1'b0;
    tick();
    n_checks++; if ({valid, empty} !== 5'b00001) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00001", {valid, empty}); end
  endtask

  task automatic test_single_word();
    tone = 32'h4000_0123;
    ld   = 1'b1;
    tick();
    n_checks++; if ({valid, empty} !== 5'b00000) begin n_fail++; $display("FAIL single_written: got %b want 00000", {valid, empty}); end
    ld = 1'b0;
    tick();
    n_checks++; if (valid !== 4'b0010) begin n_fail++; $display("FAIL single_valid: got %b want 0010", valid); end
    n_checks++; if (data !== 32'h4000_0123) begin n_fail++; $display("FAIL single_data: got %h want 40000123", data); end
    ready = 4'b1101;
    tick();
    n_checks++; if (valid !== 4'b0010 || data !== 32'h4000_0123) begin n_fail++; $display("FAIL single_hold: got %b %h want 0010 40000123", valid, data); end
    ready = 4'b0010;
    tick();
    ready = 4'b0000;
    n_checks++; if ({valid, empty} !== 5'b00001) begin n_fail++; $display("FAIL single_xfer: got %b want 00001", {valid, empty}); end
  endtask

  task automatic test_fill();
    logic [31:0] w;
    ready = 4'b0000;
    for (int k = 1; k <= 18; k++) begin
      push(fill_word(k));
      n_checks++; if (afull !== (k >= 13)) begin n_fail++; $display("FAIL fill_afull push %0d: got %b want %b", k, afull, (k >= 13)); end
      n_checks++; if (full !== (k >= 17)) begin n_fail++; $display("FAIL fill_full push %0d: got %b want %b", k, full, (k >= 17)); end
      n_checks++; if (ovf !== (k >= 18)) begin n_fail++; $display("FAIL fill_ovf push %0d: got %b want %b", k, ovf, (k >= 18)); end
    end
`ifdef TONE_FIFO_OVF_CNT_EN
    n_checks++; if (ovf_count !== 16'd1) begin n_fail++; $display("FAIL fill_ovf_count: got %0d want 1", ovf_count); end
`endif
    ready = 4'b1111;
    for (int j = 1; j <= 17; j++) begin
      w = fill_word(j);
      n_checks++; if (data !== w || valid !== (4'b0001 << w[31:30])) begin n_fail++; $display("FAIL drain word %0d: got %b %h want %b %h", j, valid, data, (4'b0001 << w[31:30]), w); end
      tick();
    end
    ready = 4'b0000;
    n_checks++; if ({valid, empty, full, afull} !== 7'b0000100) begin n_fail++; $display("FAIL drain_done: got %b want 0000100", {valid, empty, full, afull}); end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", ovf); end
`ifdef TONE_FIFO_OVF_CNT_EN
    n_checks++; if (ovf_count !== 16'd0) begin n_fail++; $display("FAIL ovf_count_clr: got %0d want 0", ovf_count); end
`endif
  endtask

  task automatic test_full_pop();
    logic [31:0] w;
    ready = 4'b0000;
    for (int k = 1; k <= 17; k++) push(fill_word(k));
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fullpop_pre_full: got %b want 1", full); end
    ready = 4'b1111;
    tone  = 32'h8000_BEEF;
    ld    = 1'b1;
    tick();
    ld    = 1'b0;
    ready = 4'b0000;
    n_checks++; if ({full, ovf} !== 2'b10) begin n_fail++; $display("FAIL fullpop_accept: got full,ovf %b want 10", {full, ovf}); end
    n_checks++; if (data !== fill_word(2)) begin n_fail++; $display("FAIL fullpop_next: got %h want %h", data, fill_word(2)); end
    tick();
    ready = 4'b1111;
    for (int j = 2; j <= 18; j++) begin
      w = (j == 18) ? 32'h8000_BEEF : fill_word(j);
      n_checks++; if (data !== w || valid !== (4'b0001 << w[31:30])) begin n_fail++; $display("FAIL fullpop_drain %0d: got %b %h want %b %h", j, valid, data, (4'b0001 << w[31:30]), w); end
      tick();
    end
    ready = 4'b0000;
    n_checks++; if ({valid, empty, ovf} !== 6'b000010) begin n_fail++; $display("FAIL fullpop_done: got %b want 000010", {valid, empty, ovf}); end
  endtask

  task automatic test_reset_mid();
    ready = 4'b0000;
    for (int k = 1; k <= 5; k++) push(fill_word(k));
    n_checks++; if (valid !== 4'b0010) begin n_fail++; $display("FAIL rstmid_pre: got %b want 0010", valid); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({valid, data} !== 36'h0) begin n_fail++; $display("FAIL rstmid_out: got %b %h want 0000 0", valid, data); end
    n_checks++; if ({full, afull, empty, ovf, bad} !== 5'b00100) begin n_fail++; $display("FAIL rstmid_flags: got %b want 00100", {full, afull, empty, ovf, bad}); end
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_checks++; if ({valid, empty} !== 5'b00001) begin n_fail++; $display("FAIL rstmid_after: got %b want 00001", {valid, empty}); end
  endtask

  task automatic test_held_strobe();
    ld  = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    n_checks++; if ({valid, empty} !== 5'b00001) begin n_fail++; $display("FAIL held_no_push: got %b want 00001", {valid, empty}); end
    ld = 1'b0;
    tick();
    tone = 32'h0000_0042;
    ld   = 1'b1;
    tick();
    ld   = 1'b0;
    tick();
    n_checks++; if (valid !== 4'b0001 || data !== 32'h0000_0042) begin n_fail++; $display("FAIL held_one_push: got %b %h want 0001 00000042", valid, data); end
    ready = 4'b0001;
    tick();
    ready = 4'b0000;
    tick();
    n_checks++; if ({valid, empty} !== 5'b00001) begin n_fail++; $display("FAIL held_only_one: got %b want 00001", {valid, empty}); end
  endtask

  task automatic test_bad_voice();
    tone3 = 32'hC000_0055;
    ld3   = 1'b1;
    tick();
    ld3   = 1'b0;
    tick();
    n_checks++; if (bad3 !== 1'b1) begin n_fail++; $display("FAIL bad_pulse: got %b want 1", bad3); end
    n_checks++; if ({valid3, empty3} !== 4'b0001) begin n_fail++; $display("FAIL bad_discard: got %b want 0001", {valid3, empty3}); end
    tick();
    n_checks++; if (bad3 !== 1'b0) begin n_fail++; $display("FAIL bad_one_cycle: got %b want 0", bad3); end
    tone3 = 32'h8000_0077;
    ld3   = 1'b1;
    tick();
    ld3   = 1'b0;
    tick();
    n_checks++; if (valid3 !== 3'b100 || data3 !== 32'h8000_0077) begin n_fail++; $display("FAIL bad_next_valid: got %b %h want 100 80000077", valid3, data3); end
    ready3 = 3'b100;
    tick();
    ready3 = 3'b000;
    n_checks++; if ({valid3, empty3, bad3} !== 5'b00010) begin n_fail++; $display("FAIL bad_next_xfer: got %b want 00010", {valid3, empty3, bad3}); end
  endtask

  initial begin
    rst     = 1'b1;
    ld      = 1'b0;
    tone    = '0;
    ready   = '0;
    ovf_clr = 1'b0;
    ld3     = 1'b0;
    tone3   = '0;
    ready3  = '0;
    test_reset();
    test_single_word();
    test_fill();
    test_full_pop();
    test_reset_mid();
    test_held_strobe();
    test_bad_voice();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
